// File: rtl/dmem_resp_pkg.sv
// Shared types and helpers for the dmem_resp data-memory responder.
// Optional byte strobes are enabled with the DMEM_RESP_BYTE_EN macro.
package dmem_pkg;

    typedef enum logic [1:0] {IDLE, WAIT, RESP} dmem_state_t;

    localparam int WORD_BYTES = 4;
    localparam int CNT_W      = 4;

    typedef struct packed {
        logic                  we;
        logic [31:0]           addr;
        logic [31:0]           wdata;
        logic [WORD_BYTES-1:0] be;
    } dmem_req_t;

    // Misaligned or outside [baseAddr, baseAddr + 4*depth); 33-bit limit so the top word is reachable.
    function automatic logic addrError(input logic [31:0] addr,
                                       input logic [31:0] baseAddr,
                                       input int unsigned depth);
        logic [32:0] limit;
        logic        misaligned;
        logic        outOfRange;
        limit      = {1'b0, baseAddr} + 33'(depth) * 33'(WORD_BYTES);
        misaligned = (addr[1:0] != 2'b00);
        outOfRange = (addr < baseAddr) || ({1'b0, addr} >= limit);
        return misaligned | outOfRange;
    endfunction

endpackage

// File: rtl/dmem_resp_if.sv
// Request/response channel between the CPU data port (master) and dmem_resp (slave).
// req_be exists only when DMEM_RESP_BYTE_EN is defined.
interface dmem_resp_if;
    import dmem_pkg::*;

    logic                  req_valid;
    logic                  req_ready;
    logic                  req_we;
    logic [31:0]           req_addr;
    logic [31:0]           req_wdata;
`ifdef DMEM_RESP_BYTE_EN
    logic [WORD_BYTES-1:0] req_be;
`endif
    logic                  rsp_valid;
    logic                  rsp_ready;
    logic [31:0]           rsp_rdata;
    logic                  rsp_err;

    modport master (
        output req_valid, req_we, req_addr, req_wdata,
`ifdef DMEM_RESP_BYTE_EN
        output req_be,
`endif
        input  req_ready,
        input  rsp_valid, rsp_rdata, rsp_err,
        output rsp_ready
    );

    modport slave (
        input  req_valid, req_we, req_addr, req_wdata,
`ifdef DMEM_RESP_BYTE_EN
        input  req_be,
`endif
        output req_ready,
        output rsp_valid, rsp_rdata, rsp_err,
        input  rsp_ready
    );

endinterface

// File: rtl/dmem_resp_array.sv
// Single-port word RAM with per-byte write enables; read data is registered on the access edge.
module dmem_resp_array
    import dmem_pkg::*;
#(
    parameter int DEPTH = 256,
    parameter int IDX_W = $clog2(DEPTH)
) (
    input  logic                  clk,
    input  logic                  en,
    input  logic [WORD_BYTES-1:0] byteWe,
    input  logic [IDX_W-1:0]      idx,
    input  logic [31:0]           wdata,
    output logic [31:0]           rdata
);

    logic [31:0] mem [DEPTH];

    // NOTE: storage has no reset; contents survive rst and a RAM macro can be inferred.
    always_ff @(posedge clk) begin
        if (en) begin
            for (int b = 0; b < WORD_BYTES; b++) begin
                if (byteWe[b]) begin
                    mem[idx][8*b +: 8] <= wdata[8*b +: 8];
                end
            end
            rdata <= mem[idx];
        end
    end

endmodule

// File: rtl/dmem_resp.sv
// Fixed-latency data-memory responder: one load/store in flight, errors on misaligned/out-of-range.
// Define DMEM_RESP_BYTE_EN to add per-lane store strobes (req_be).
module dmem_resp
    import dmem_pkg::*;
#(
    parameter int          DEPTH     = 256,
    parameter int          LATENCY   = 2,
    parameter logic [31:0] BASE_ADDR = 32'h0000_0000
) (
    input  logic        clk,
    input  logic        rst,
    dmem_resp_if.slave  bus
);

    localparam int IDX_W = $clog2(DEPTH);

    dmem_state_t           state;
    dmem_state_t           stateNext;
    logic [CNT_W-1:0]      count;
    logic [CNT_W-1:0]      countNext;
    dmem_req_t             incoming;
    dmem_req_t             req;
    logic                  reqErr;
    logic                  accept;
    logic                  doAccess;
    logic [IDX_W-1:0]      wordIdx;
    logic [WORD_BYTES-1:0] ramWe;
    logic [31:0]           ramRdata;

    always_comb begin
        incoming.we    = bus.req_we;
        incoming.addr  = bus.req_addr;
        incoming.wdata = bus.req_wdata;
`ifdef DMEM_RESP_BYTE_EN
        incoming.be    = bus.req_be;
`else
        incoming.be    = '1;
`endif
    end

    // NOTE: every output of this block is defaulted first so no path leaves one unassigned (no latches).
    always_comb begin
        stateNext     = state;
        countNext     = count;
        accept        = 1'b0;
        doAccess      = 1'b0;
        bus.req_ready = 1'b0;
        bus.rsp_valid = 1'b0;
        // Outputs stay quiet in the cycle reset is sampled, not just the one after.
        if (!rst) begin
            case (state)
                IDLE: begin
                    bus.req_ready = 1'b1;
                    if (bus.req_valid) begin
                        accept    = 1'b1;
                        countNext = CNT_W'(LATENCY - 1);
                        stateNext = WAIT;
                    end
                end
                WAIT: begin
                    if (count == '0) begin
                        doAccess  = 1'b1;
                        stateNext = RESP;
                    end else begin
                        countNext = count - CNT_W'(1);
                    end
                end
                RESP: begin
                    bus.rsp_valid = 1'b1;
                    if (bus.rsp_ready) begin
                        stateNext = IDLE;
                    end
                end
                default: stateNext = IDLE;
            endcase
        end
        bus.rsp_rdata = (bus.rsp_valid && !req.we && !reqErr) ? ramRdata : 32'h0;
        bus.rsp_err   = bus.rsp_valid && reqErr;
    end

    // NOTE: state is updated with non-blocking assignments so every flop samples pre-edge values.
    always_ff @(posedge clk) begin
        if (rst) begin
            state <= IDLE;
            count <= '0;
        end else begin
            state <= stateNext;
            count <= countNext;
        end
    end

    // Captured request only matters from WAIT onward, so it needs no reset.
    always_ff @(posedge clk) begin
        if (accept) begin
            req    <= incoming;
            reqErr <= addrError(bus.req_addr, BASE_ADDR, DEPTH);
        end
    end

    // Index is taken only after the range check, so truncation cannot alias a valid word.
    assign wordIdx = IDX_W'((req.addr - BASE_ADDR) >> 2);
    assign ramWe   = (doAccess && req.we && !reqErr) ? req.be : '0;

    dmem_resp_array #(
        .DEPTH (DEPTH)
    ) u_array (
        .clk    (clk),
        .en     (doAccess),
        .byteWe (ramWe),
        .idx    (wordIdx),
        .wdata  (req.wdata),
        .rdata  (ramRdata)
    );

endmodule

// File: tb/tb_dmem_resp.sv
// Self-checking bench for dmem_resp: reset, directed table, corner sequences and random traffic vs a word-array model.
module tb_dmem_resp;

    localparam int          DEPTH   = 256;
    localparam int          LATENCY = 2;
    localparam logic [31:0] BASE    = 32'h0000_0000;

    typedef struct {
        bit          we;
        logic [31:0] addr;
        logic [31:0] wdata;
        logic [3:0]  be;
        bit          expErr;
        logic [31:0] expRdata;
    } vec_t;

    logic clk = 1'b0;
    logic rst = 1'b1;
    int   checks = 0;
    int   failures = 0;

    logic [31:0] modelMem [DEPTH];

    dmem_resp_if bus ();

    dmem_resp #(
        .DEPTH     (DEPTH),
        .LATENCY   (LATENCY),
        .BASE_ADDR (BASE)
    ) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus.slave)
    );

    always #5 clk = ~clk;

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog expired");
    end

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: actual=%h required=%h", name, act, exp);
        end
    endtask

    // Reference: flat word array addressed by byte address, errors from the address rules.
    function automatic void modelAccess(input bit we, input logic [31:0] addr, input logic [31:0] wdata,
                                        input logic [3:0] be, output bit err, output logic [31:0] rdata);
        longint unsigned a  = 64'(addr);
        longint unsigned lo = 64'(BASE);
        longint unsigned hi = 64'(BASE) + 64'(4 * DEPTH);
        int idx;
        err   = (a % 64'd4 != 64'd0) || (a < lo) || (a >= hi);
        rdata = 32'h0;
        if (err) return;
        idx = int'((a - lo) / 64'd4);
        if (we) begin
            for (int b = 0; b < 4; b++) begin
                if (be[b]) modelMem[idx][8*b +: 8] = wdata[8*b +: 8];
            end
        end else begin
            rdata = modelMem[idx];
        end
    endfunction

    task automatic setBe(input logic [3:0] be);
`ifdef DMEM_RESP_BYTE_EN
        bus.req_be = be;
`else
        if (be != 4'hF) $display("note: byte strobes ignored in this build");
`endif
    endtask

    // Present one request and return just after its acceptance edge; junk on req_* while busy.
    task automatic startReq(input bit we, input logic [31:0] addr, input logic [31:0] wdata, input logic [3:0] be);
        int waited = 0;
        while (bus.req_ready !== 1'b1 && waited < 20) begin
            @(posedge clk); #1;
            waited++;
        end
        check("req_ready before request", 32'(bus.req_ready), 32'd1);
        bus.req_valid = 1'b1;
        bus.req_we    = we;
        bus.req_addr  = addr;
        bus.req_wdata = wdata;
        setBe(be);
        @(posedge clk); #1;
        bus.req_valid = 1'($urandom_range(0, 1));
        bus.req_we    = 1'b1;
        bus.req_addr  = BASE + (32'($urandom_range(0, DEPTH - 1)) << 2);
        bus.req_wdata = $urandom;
    endtask

    task automatic doTxn(input string name, input bit we, input logic [31:0] addr, input logic [31:0] wdata,
                         input logic [3:0] be, input int hold, input bit early,
                         input bit expErr, input logic [31:0] expRdata);
        int lat = 0;
        startReq(we, addr, wdata, be);
        if (early) bus.rsp_ready = 1'b1;
        while (bus.rsp_valid !== 1'b1 && lat < 20) begin
            check({name, " req_ready low in WAIT"}, 32'(bus.req_ready), 32'd0);
            @(posedge clk); #1;
            lat++;
        end
        check({name, " latency"}, 32'(lat), 32'(LATENCY));
        check({name, " rsp_err"}, 32'(bus.rsp_err), 32'(expErr));
        check({name, " rsp_rdata"}, bus.rsp_rdata, expRdata);
        check({name, " req_ready low in RESP"}, 32'(bus.req_ready), 32'd0);
        for (int i = 0; i < hold; i++) begin
            @(posedge clk); #1;
            check({name, " rsp_valid held"}, 32'(bus.rsp_valid), 32'd1);
            check({name, " rsp_rdata held"}, bus.rsp_rdata, expRdata);
            check({name, " rsp_err held"}, 32'(bus.rsp_err), 32'(expErr));
            check({name, " req_ready held low"}, 32'(bus.req_ready), 32'd0);
        end
        bus.rsp_ready = 1'b1;
        @(posedge clk); #1;
        bus.rsp_ready = 1'b0;
        bus.req_valid = 1'b0;
        check({name, " rsp_valid after handshake"}, 32'(bus.rsp_valid), 32'd0);
        check({name, " req_ready after handshake"}, 32'(bus.req_ready), 32'd1);
    endtask

    // Updates the model alongside a directed transaction whose expectations are hand-written.
    task automatic directed(input string name, input bit we, input logic [31:0] addr, input logic [31:0] wdata,
                            input logic [3:0] be, input int hold, input bit expErr, input logic [31:0] expRdata);
        bit          mErr;
        logic [31:0] mRdata;
        modelAccess(we, addr, wdata, be, mErr, mRdata);
        doTxn(name, we, addr, wdata, be, hold, 1'b0, expErr, expRdata);
    endtask

    vec_t vecs[$];

    initial begin
        bus.req_valid = 1'b0;
        bus.req_we    = 1'b0;
        bus.req_addr  = 32'h0;
        bus.req_wdata = 32'h0;
        bus.rsp_ready = 1'b0;
        setBe(4'hF);

        // Reset behaviour
        rst = 1'b1;
        repeat (3) @(posedge clk);
        #1;
        check("reset req_ready", 32'(bus.req_ready), 32'd0);
        check("reset rsp_valid", 32'(bus.rsp_valid), 32'd0);
        check("reset rsp_rdata", bus.rsp_rdata, 32'h0);
        check("reset rsp_err", 32'(bus.rsp_err), 32'd0);
        rst = 1'b0;
        @(posedge clk); #1;
        check("post-reset req_ready", 32'(bus.req_ready), 32'd1);
        check("post-reset rsp_valid", 32'(bus.rsp_valid), 32'd0);
        check("post-reset rsp_rdata", bus.rsp_rdata, 32'h0);
        check("post-reset rsp_err", 32'(bus.rsp_err), 32'd0);

        // Preload every word so all later loads have a defined expectation
        for (int i = 0; i < DEPTH; i++) begin
            logic [31:0] d = $urandom;
            directed("preload", 1'b1, BASE + 32'(i * 4), d, 4'hF, 0, 1'b0, 32'h0);
        end

        // Directed table
        vecs.push_back('{1'b1, 32'h0000_0010, 32'hDEAD_BEEF, 4'hF, 1'b0, 32'h0});
        vecs.push_back('{1'b0, 32'h0000_0010, 32'h0,         4'hF, 1'b0, 32'hDEAD_BEEF});
        vecs.push_back('{1'b1, 32'h0000_0000, 32'hCAFE_F00D, 4'hF, 1'b0, 32'h0});
        vecs.push_back('{1'b0, 32'h0000_0012, 32'h0,         4'hF, 1'b1, 32'h0});
        vecs.push_back('{1'b1, 32'h0000_0400, 32'h5555_5555, 4'hF, 1'b1, 32'h0});
        vecs.push_back('{1'b0, 32'h0000_0000, 32'h0,         4'hF, 1'b0, 32'hCAFE_F00D});
        vecs.push_back('{1'b1, 32'h0000_03FC, 32'hA5A5_A5A5, 4'hF, 1'b0, 32'h0});
        vecs.push_back('{1'b1, 32'hFFFF_FFFC, 32'h0BAD_0BAD, 4'hF, 1'b1, 32'h0});
        vecs.push_back('{1'b0, 32'h0000_03FF, 32'h0,         4'hF, 1'b1, 32'h0});
        vecs.push_back('{1'b1, 32'h0000_0011, 32'h7777_7777, 4'hF, 1'b1, 32'h0});
        vecs.push_back('{1'b0, 32'h0000_03FC, 32'h0,         4'hF, 1'b0, 32'hA5A5_A5A5});
        vecs.push_back('{1'b0, 32'h0000_0010, 32'h0,         4'hF, 1'b0, 32'hDEAD_BEEF});
        for (int i = 0; i < vecs.size(); i++) begin
            directed($sformatf("vec%0d", i), vecs[i].we, vecs[i].addr, vecs[i].wdata, vecs[i].be,
                     i % 3, vecs[i].expErr, vecs[i].expRdata);
        end

        // Response backpressure for five cycles
        directed("backpressure", 1'b0, 32'h0000_0010, 32'h0, 4'hF, 5, 1'b0, 32'hDEAD_BEEF);

        // Reset during WAIT of a store: the store must not land
        directed("pre-reset store", 1'b1, 32'h0000_0020, 32'h0BAD_F00D, 4'hF, 0, 1'b0, 32'h0);
        startReq(1'b1, 32'h0000_0020, 32'h1234_5678, 4'hF);
        rst = 1'b1;
        bus.req_valid = 1'b0;
        #1;
        check("mid-reset req_ready", 32'(bus.req_ready), 32'd0);
        check("mid-reset rsp_valid", 32'(bus.rsp_valid), 32'd0);
        repeat (2) @(posedge clk);
        #1;
        check("mid-reset rsp_valid later", 32'(bus.rsp_valid), 32'd0);
        check("mid-reset rsp_rdata", bus.rsp_rdata, 32'h0);
        rst = 1'b0;
        @(posedge clk); #1;
        check("after mid-reset req_ready", 32'(bus.req_ready), 32'd1);
        directed("abandoned store", 1'b0, 32'h0000_0020, 32'h0, 4'hF, 0, 1'b0, 32'h0BAD_F00D);
        directed("word0 kept", 1'b0, 32'h0000_0000, 32'h0, 4'hF, 0, 1'b0, 32'hCAFE_F00D);

`ifdef DMEM_RESP_BYTE_EN
        directed("be preload", 1'b1, 32'h0000_0030, 32'h1122_3344, 4'hF, 0, 1'b0, 32'h0);
        directed("be store", 1'b1, 32'h0000_0030, 32'hAABB_CCDD, 4'b0101, 0, 1'b0, 32'h0);
        directed("be load", 1'b0, 32'h0000_0030, 32'h0, 4'b0000, 0, 1'b0, 32'h11BB_33DD);
        directed("be zero store", 1'b1, 32'h0000_0030, 32'hFFFF_FFFF, 4'b0000, 0, 1'b0, 32'h0);
        directed("be zero load", 1'b0, 32'h0000_0030, 32'h0, 4'hF, 1, 1'b0, 32'h11BB_33DD);
`endif

        // Random traffic against the model
        for (int n = 0; n < 300; n++) begin
            bit          we    = 1'($urandom_range(0, 1));
            int          sel   = $urandom_range(0, 9);
            logic [31:0] wdata = $urandom;
            logic [3:0]  be    = 4'hF;
            logic [31:0] addr;
            int          hold  = $urandom_range(0, 3);
            bit          early = (hold == 0) && ($urandom_range(0, 1) == 1);
            bit          eErr;
            logic [31:0] eRdata;
`ifdef DMEM_RESP_BYTE_EN
            be = 4'($urandom_range(0, 15));
`endif
            if (sel < 4)       addr = BASE + (32'($urandom_range(0, 15)) << 2);
            else if (sel < 7)  addr = BASE + (32'($urandom_range(0, DEPTH - 1)) << 2);
            else if (sel == 7) addr = BASE + (32'($urandom_range(0, DEPTH - 1)) << 2) + 32'($urandom_range(1, 3));
            else if (sel == 8) addr = BASE + 32'(4 * DEPTH) + (32'($urandom_range(0, 63)) << 2);
            else               addr = $urandom;
            modelAccess(we, addr, wdata, be, eErr, eRdata);
            doTxn("random", we, addr, wdata, be, hold, early, eErr, eRdata);
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
